ex_alu_md: RTL
==============

// Module: ex_alu_md
// PURPOSE
//  Execute-stage datapath. Consumes the 5-bit alucontrol from the ALU decoder via the ID/EX register.
//  Computes single-cycle ALU results and owns the HI/LO registers.
//  Runs an iterative 32-cycle divider and stalls the pipeline while the divider is busy.
//  Sits between the ID/EX register and the EX/MEM register; stall_e goes to the hazard unit.
// PARAMETERS
//  WIDTH     32  datapath width; the divider iterates WIDTH cycles
//  CTRL_W     5  alucontrol width; codes come from the shared *_CONTROL defines
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous reset, active-low
//  valid_e      in   1      EX holds a real instruction (0 = bubble)
//  flush_e      in   1      kill the EX instruction; aborts the divider
//  stall_ext    in   1      EX held by another hazard source
//  alucontrol_e in   CTRL_W operation: ADD,SUB,AND,OR,XOR,NOR,SLT,LUI,MULT,MULTU,DIV,DIVU,MFHI,MFLO,MTHI,MTLO _CONTROL
//  srca_e       in   WIDTH  operand A (rs)
//  srcb_e       in   WIDTH  operand B (rt or extended immediate)
//  aluout_e     out  WIDTH  result (combinational)
//  zero_e       out  1      aluout_e == 0
//  overflow_e   out  1      signed overflow of ADD/SUB; raw, qualified downstream
//  stall_e      out  1      hold IF/ID/EX while the divider is busy
//  hi_o, lo_o   out  WIDTH  architectural HI/LO (registered)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, count=0, hi_o=lo_o=0, stall_e=0.
//   aluout_e, zero_e and overflow_e follow the combinational inputs.
//  Single-cycle ops, combinational:
//   LUI = {srcb[15:0],16'b0}. SLT is a signed compare giving 0 or 1.
//   MFHI/MFLO return hi_o/lo_o. Any undefined code gives aluout_e=0.
//  HI/LO commit at the clock edge when valid_e=1, flush_e=0, state=IDLE:
//   MULT/MULTU: {hi,lo} = signed/unsigned 64-bit product.
//   MTHI: hi=srca. MTLO: lo=srca.
//   Repeats under stall_ext are idempotent.
//  Divider FSM (IDLE, BUSY, DONE); start = valid_e & ~flush_e & (DIV|DIVU) & state==IDLE.
//   IDLE -start-> BUSY: latch |A|,|B| (DIVU: raw), both result signs, count=0.
//   BUSY: one restoring-divide step per cycle, count++.
//    On the edge with count==WIDTH-1: write lo=quotient and hi=remainder, then go to DONE.
//    Sign fix: quotient is negative if the signs differ; remainder takes the dividend's sign.
//   DONE: stall_e=0; stay in DONE while stall_ext=1, otherwise go to IDLE. This prevents a restart of the held DIV.
//   stall_e = start | (state==BUSY). A DIV therefore stalls for exactly WIDTH+1 cycles.
//  Flush in BUSY or DONE: go to IDLE next edge, HI/LO unchanged, stall_e low the next cycle.
//  Divide by zero: no trap; result is whatever the algorithm produces.
//   DIVU: lo=all ones, hi=dividend.
//   DIV gives the same result with the sign fix applied.
//  DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//  Reset mid-divide: immediate IDLE, HI=LO=0.
// TESTING
//  1 ADD 0x7FFFFFFF+1 -> aluout=0x80000000, overflow_e=1.
//    SLT 0xFFFFFFFF,1 -> 1. LUI srcb=0x1234 -> 0x12340000.
//  2 MULT 0xFFFFFFFE*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//    MULTU same operands -> hi=2, lo=0xFFFFFFFA. Commits one edge later.
//  3 DIV 0xFFFFFFF9 / 2 -> stall_e high 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    MFLO in the next instruction reads 0xFFFFFFFD.
//  4 DIVU 100/0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5 flush_e at BUSY cycle 10 -> stall_e low next cycle, HI/LO keep prior values.
//    A new DIV then restarts cleanly.
//  6 rst low mid-divide -> stall_e=0, hi=lo=0 at once.
//    stall_ext=1 for 3 cycles in DONE -> no second divide, HI/LO unchanged.

Source files
------------

// File: rtl/ex_alu_md_if.sv
// EX-stage bus between the ID/EX register side and the ALU/multiply-divide unit,
// plus the shared alucontrol code points.
`ifndef EX_ALU_CONTROL_DEFS
`define EX_ALU_CONTROL_DEFS
`define ADD_CONTROL   5'd0
`define SUB_CONTROL   5'd1
`define AND_CONTROL   5'd2
`define OR_CONTROL    5'd3
`define XOR_CONTROL   5'd4
`define NOR_CONTROL   5'd5
`define SLT_CONTROL   5'd6
`define LUI_CONTROL   5'd7
`define MULT_CONTROL  5'd8
`define MULTU_CONTROL 5'd9
`define DIV_CONTROL   5'd10
`define DIVU_CONTROL  5'd11
`define MFHI_CONTROL  5'd12
`define MFLO_CONTROL  5'd13
`define MTHI_CONTROL  5'd14
`define MTLO_CONTROL  5'd15
`endif

interface ex_alu_md_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
);
  logic              valid_e;
  logic              flush_e;
  logic              stall_ext;
  logic [CTRL_W-1:0] alucontrol_e;
  logic [WIDTH-1:0]  srca_e;
  logic [WIDTH-1:0]  srcb_e;
  logic [WIDTH-1:0]  aluout_e;
  logic              zero_e;
  logic              overflow_e;
  logic              stall_e;
  logic [WIDTH-1:0]  hi_o;
  logic [WIDTH-1:0]  lo_o;

  modport master (
    output valid_e, flush_e, stall_ext, alucontrol_e, srca_e, srcb_e,
    input  aluout_e, zero_e, overflow_e, stall_e, hi_o, lo_o
  );

  modport slave (
    input  valid_e, flush_e, stall_ext, alucontrol_e, srca_e, srcb_e,
    output aluout_e, zero_e, overflow_e, stall_e, hi_o, lo_o
  );
endinterface

// File: rtl/ex_alu_md.sv
// Execute-stage ALU with HI/LO registers, single-cycle multiply and a
// WIDTH-cycle restoring divider that stalls the pipeline while it runs.
module ex_alu_md #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_alu_md_if.slave     bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_quo_q, neg_rem_q;

  logic [WIDTH-1:0]  a, b;
  logic [CTRL_W-1:0] op;
  assign a  = bus.srca_e;
  assign b  = bus.srcb_e;
  assign op = bus.alucontrol_e;

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH-1:0] sum, diff, result;
  logic             ovf, slt;
  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      `ADD_CONTROL: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      `SUB_CONTROL: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      `AND_CONTROL:  result = a & b;
      `OR_CONTROL:   result = a | b;
      `XOR_CONTROL:  result = a ^ b;
      `NOR_CONTROL:  result = ~(a | b);
      `SLT_CONTROL:  result = {{(WIDTH-1){1'b0}}, slt};
      `LUI_CONTROL:  result = {b[15:0], {(WIDTH-16){1'b0}}};
      `MFHI_CONTROL: result = hi_q;
      `MFLO_CONTROL: result = lo_q;
      default:       result = '0;
    endcase
  end

  assign bus.aluout_e   = result;
  assign bus.zero_e     = (result == '0);
  assign bus.overflow_e = ovf;

  // ---------------- multiply ----------------
  logic [2*WIDTH-1:0] prod_s, prod_u;
  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // ---------------- divider datapath ----------------
  logic             is_div, is_divu, idle, issue, start;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign is_div  = (op == `DIV_CONTROL);
  assign is_divu = (op == `DIVU_CONTROL);
  assign idle    = (state_q == S_IDLE);
  assign issue   = bus.valid_e & ~bus.flush_e & idle;
  assign start   = issue & (is_div | is_divu);
  assign a_abs   = (is_div && a[WIDTH-1]) ? -a : a;
  assign b_abs   = (is_div && b[WIDTH-1]) ? -b : b;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  logic [WIDTH:0]   r_shift, r_sub;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step, quo_fix, rem_fix;
  assign r_shift  = {rem_q, quo_q[WIDTH-1]};
  assign r_sub    = r_shift - {1'b0, dvs_q};
  assign fits     = ~r_sub[WIDTH];
  assign rem_step = fits ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], fits};
  assign quo_fix  = neg_quo_q ? -quo_step : quo_step;
  assign rem_fix  = neg_rem_q ? -rem_step : rem_step;

  assign bus.stall_e = start | (state_q == S_BUSY);
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            case (op)
              `MULT_CONTROL:  {hi_q, lo_q} <= prod_s;
              `MULTU_CONTROL: {hi_q, lo_q} <= prod_u;
              `MTHI_CONTROL:  hi_q <= a;
              `MTLO_CONTROL:  lo_q <= a;
              default: ;
            endcase
          end
          if (start) begin
            state_q   <= S_BUSY;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvs_q     <= b_abs;
            neg_quo_q <= is_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= is_div & a[WIDTH-1];
          end
        end
        S_BUSY: begin
          if (bus.flush_e) begin
            state_q <= S_IDLE;
          end else begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_STEP) begin
              lo_q    <= quo_fix;
              hi_q    <= rem_fix;
              state_q <= S_DONE;
            end
          end
        end
        // Holding here while EX is stalled keeps the same DIV from restarting.
        S_DONE: begin
          if (bus.flush_e || !bus.stall_ext) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
